// File: rtl/pl_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// fault cause codes and the transaction FSM state type.
package pl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    CAUSE_MISALIGN = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } fault_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Encodings with no RV32I load/store meaning, plus stores of the unsigned forms.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr);
    return ((f3[1:0] == F3_H[1:0]) && addr[0]) ||
           ((f3[1:0] == F3_W[1:0]) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/pl_lsu_align.sv
// Byte-lane steering for stores and byte/half extraction with sign or zero
// extension for loads. Purely combinational.
module pl_lsu_align
  import pl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata_c,
  output logic [3:0]  o_wstrb_c,
  output logic [31:0] o_rdata_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store data is replicated across lanes so the strobes alone pick the target bytes.
  always_comb begin
    o_wdata_c = i_wdata;
    o_wstrb_c = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        o_wdata_c = {4{i_wdata[7:0]}};
        o_wstrb_c = 4'b0001 << i_addr;
      end
      2'b01: begin
        o_wdata_c = {2{i_wdata[15:0]}};
        o_wstrb_c = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_rdata_c = i_rdata;
    case (i_funct3)
      F3_B:    o_rdata_c = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata_c = {{16{w_half[15]}}, w_half};
      F3_BU:   o_rdata_c = {24'd0, w_byte};
      F3_HU:   o_rdata_c = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/pl_mem_lsu.sv
// Memory-stage load/store unit: runs one valid/ready bus transaction per
// M-stage memory op, stalls the pipeline meanwhile and reports faults.
module pl_mem_lsu
  import pl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        RegWriteM,
  output logic        RegWriteOutM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemFaultM,
  output logic [1:0]  FaultCauseM,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_t   r_state;
  logic [TO_W-1:0] r_wdog;
  logic [31:0]  r_read_data;
  logic         r_fault;
  fault_cause_t r_cause;

  logic        w_op, w_illegal, w_misal, w_idle, w_issue, w_bad;
  logic        w_busy, w_timeout, w_bus_valid;
  logic [31:0] w_lane_wdata, w_load_ext;
  logic [3:0]  w_lane_wstrb;

  pl_lsu_align u_align (
    .i_funct3  (Funct3M),
    .i_addr    (ALUResultM[1:0]),
    .i_wdata   (WriteDataM),
    .i_rdata   (bus_rdata),
    .o_wdata_c (w_lane_wdata),
    .o_wstrb_c (w_lane_wstrb),
    .o_rdata_c (w_load_ext)
  );

  assign w_op      = MemReadM | MemWriteM;
  assign w_illegal = f3_illegal(Funct3M, MemWriteM) | (MemReadM & MemWriteM);
  assign w_misal   = f3_misaligned(Funct3M, ALUResultM[1:0]);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_issue   = w_idle & w_op & ~w_illegal & ~w_misal;
  assign w_bad     = w_idle & w_op & (w_illegal | w_misal);
  assign w_busy    = (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign w_timeout = w_busy & (r_wdog == TO_W'(TIMEOUT_CYCLES - 1));

  // Everything toward the bus and pipeline is forced quiet while reset is held.
  assign w_bus_valid  = ~rst & (w_issue | ((r_state == ST_REQ) & ~w_timeout));
  assign bus_valid    = w_bus_valid;
  assign bus_we       = w_bus_valid & MemWriteM;
  assign bus_addr     = w_bus_valid ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign bus_wdata    = bus_we ? w_lane_wdata : 32'd0;
  assign bus_wstrb    = bus_we ? w_lane_wstrb : 4'd0;
  assign StallM       = ~rst & (w_issue | (w_busy & ~w_timeout));
  assign RegWriteOutM = ~rst & RegWriteM & ((w_idle & ~w_op) | (r_state == ST_DONE));

  assign ReadDataM   = r_read_data;
  assign MemFaultM   = r_fault;
  assign FaultCauseM = r_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wdog      <= '0;
      r_read_data <= 32'd0;
      r_fault     <= 1'b0;
      r_cause     <= CAUSE_MISALIGN;
    end else begin
      r_fault <= 1'b0;
      r_cause <= CAUSE_MISALIGN;
      case (r_state)
        ST_IDLE: begin
          if (w_bad) begin
            r_fault <= 1'b1;
            r_cause <= w_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
          end else if (w_issue) begin
            r_wdog <= '0;
            if (bus_ready) r_state <= MemWriteM ? ST_DONE : ST_WAIT;
            else           r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_timeout) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end else if (bus_ready) begin
            r_wdog  <= '0;
            r_state <= MemWriteM ? ST_DONE : ST_WAIT;
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        ST_WAIT: begin
          if (w_timeout) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b1;
            r_cause <= CAUSE_TIMEOUT;
          end else if (bus_rvalid) begin
            r_read_data <= w_load_ext;
            r_state     <= ST_DONE;
          end else begin
            r_wdog <= r_wdog + TO_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_lsu.sv
// Scoreboard bench for pl_mem_lsu: expected bus requests and op results are
// queued when an op is driven and compared when the DUT handshakes/completes.
module tb_pl_mem_lsu;

  localparam int unsigned TIMEOUT = 64;
  localparam int BUDGET = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, RegWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        RegWriteOutM, StallM, MemFaultM;
  logic [31:0] ReadDataM;
  logic [1:0]  FaultCauseM;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  pl_mem_lsu #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RegWriteM(RegWriteM),
    .RegWriteOutM(RegWriteOutM), .ReadDataM(ReadDataM), .StallM(StallM),
    .MemFaultM(MemFaultM), .FaultCauseM(FaultCauseM),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct {
    int          stall;
    logic        rw;
    logic        chk_rd;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  function automatic logic m_illegal(input logic rd, input logic wr, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4) || (rd && wr);
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
    return ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * a[1:0]);
    case (f3)
      3'd0:    return (sh[7] ? 32'hFFFFFF00 : 32'h0) | (sh & 32'hFF);
      3'd1:    return (sh[15] ? 32'hFFFF0000 : 32'h0) | (sh & 32'hFFFF);
      3'd4:    return sh & 32'hFF;
      3'd5:    return sh & 32'hFFFF;
      default: return d;
    endcase
  endfunction

  function automatic bus_exp_t m_bus(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus_exp_t b;
    b.we    = wr;
    b.addr  = a & 32'hFFFFFFFC;
    b.wdata = 32'd0;
    b.wstrb = 4'd0;
    if (wr) begin
      case (f3)
        3'd0:    begin b.wdata = (wd & 32'hFF) * 32'h01010101; b.wstrb = 4'(1 << a[1:0]); end
        3'd1:    begin b.wdata = (wd & 32'hFFFF) * 32'h00010001; b.wstrb = a[1] ? 4'hC : 4'h3; end
        default: begin b.wdata = wd; b.wstrb = 4'hF; end
      endcase
    end
    return b;
  endfunction

  // rdy_lat < 0 means the bus never accepts; rv_lat counts cycles from handshake to rvalid.
  task automatic do_op(input string name, input logic rd, input logic wr, input logic rw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int rdy_lat, input int rv_lat);
    res_exp_t re, ro;
    bus_exp_t bo;
    logic bad, done, seen_valid, unstable;
    logic [31:0] a0;
    int c, hs, stall_n;

    bad = m_illegal(rd, wr, f3) || m_misal(f3, addr);
    re.chk_rd = 1'b0;
    re.rdata  = 32'd0;
    if (bad) begin
      re.stall = 0; re.rw = 1'b0; re.fault = 1'b1;
      re.cause = m_illegal(rd, wr, f3) ? 2'd1 : 2'd0;
    end else if (rdy_lat < 0) begin
      re.stall = TIMEOUT; re.rw = 1'b0; re.fault = 1'b1; re.cause = 2'd2;
    end else begin
      bus_q.push_back(m_bus(wr, f3, addr, wd));
      re.stall  = wr ? rdy_lat + 1 : rdy_lat + rv_lat + 1;
      re.rw     = rw;
      re.fault  = 1'b0;
      re.cause  = 2'd0;
      re.chk_rd = rd;
      re.rdata  = m_load(f3, addr, rdat);
    end
    res_q.push_back(re);

    MemReadM = rd; MemWriteM = wr; RegWriteM = rw;
    Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    c = 0; hs = -1; stall_n = 0; done = 1'b0;
    seen_valid = 1'b0; unstable = 1'b0; a0 = 32'd0;
    while (!done && c < BUDGET) begin
      bus_ready  = (rdy_lat >= 0) && (c >= rdy_lat);
      bus_rvalid = rd && (hs >= 0) && (c == hs + rv_lat);
      bus_rdata  = bus_rvalid ? rdat : 32'hDEADBEEF;
      @(negedge clk);
      if (bus_valid) begin
        if (!seen_valid) a0 = bus_addr;
        else if (bus_addr !== a0) unstable = 1'b1;
        seen_valid = 1'b1;
      end
      if (bus_valid && bus_ready && hs < 0) begin
        hs = c;
        if (bus_q.size() == 0) begin
          check({name, ":unexpected_req"}, 32'd1, 32'd0);
        end else begin
          bo = bus_q.pop_front();
          check({name, ":bus_we"}, 32'(bus_we), 32'(bo.we));
          check({name, ":bus_addr"}, bus_addr, bo.addr);
          check({name, ":bus_wdata"}, bus_wdata, bo.wdata);
          check({name, ":bus_wstrb"}, 32'(bus_wstrb), 32'(bo.wstrb));
        end
      end
      if (StallM) stall_n++;
      else begin
        done = 1'b1;
        ro = res_q.pop_front();
        check({name, ":stall_cycles"}, 32'(stall_n), 32'(ro.stall));
        check({name, ":regwrite_out"}, 32'(RegWriteOutM), 32'(ro.rw));
        if (ro.chk_rd) check({name, ":read_data"}, ReadDataM, ro.rdata);
        if (ro.fault) check({name, ":no_valid_at_end"}, 32'(bus_valid), 32'd0);
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) begin
      check({name, ":budget"}, 32'd1, 32'd0);
      void'(res_q.pop_front());
    end
    if (bad) check({name, ":no_request"}, 32'(seen_valid), 32'd0);
    if (seen_valid) check({name, ":addr_stable"}, 32'(unstable), 32'd0);

    // Following cycle: back in IDLE with a no-op, fault pulse visible now.
    MemReadM = 1'b0; MemWriteM = 1'b0; RegWriteM = 1'b1;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    check({name, ":fault"}, 32'(MemFaultM), 32'(re.fault));
    check({name, ":cause"}, 32'(FaultCauseM), 32'(re.cause));
    check({name, ":idle_regwrite"}, 32'(RegWriteOutM), 32'd1);
    check({name, ":idle_stall"}, 32'(StallM), 32'd0);
    @(posedge clk); #1;
    if (re.fault) begin
      @(negedge clk);
      check({name, ":fault_one_cycle"}, 32'(MemFaultM), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; RegWriteM = 1'b1;
    Funct3M = 3'd0; ALUResultM = 32'd0; WriteDataM = 32'd0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst:stall", 32'(StallM), 32'd0);
    check("rst:regwrite", 32'(RegWriteOutM), 32'd0);
    check("rst:bus_valid", 32'(bus_valid), 32'd0);
    check("rst:read_data", ReadDataM, 32'd0);
    check("rst:fault", 32'(MemFaultM), 32'd0);
    check("rst:cause", 32'(FaultCauseM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle:regwrite", 32'(RegWriteOutM), 32'd1);
    @(posedge clk); #1;

    do_op("sb_1003",   1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
    do_op("lh_2002",   1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);
    do_op("lhu_2002",  1'b1, 1'b0, 1'b1, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1);
    do_op("lw_mis",    1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_3001, 32'h0, 32'h0, 0, 1);
    do_op("lw_slow",   1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_4000, 32'h0, 32'h1357_9BDF, 5, 3);
    do_op("lb_5001",   1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_5001, 32'h0, 32'h0000_8000, 1, 2);
    do_op("lbu_5003",  1'b1, 1'b0, 1'b1, 3'd4, 32'h0000_5003, 32'h0, 32'hAB00_0000, 0, 1);
    do_op("sh_6002",   1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_6002, 32'h1234_BEEF, 32'h0, 2, 0);
    do_op("sw_7000",   1'b0, 1'b1, 1'b0, 3'd2, 32'h0000_7000, 32'hCAFE_F00D, 32'h0, 0, 0);
    do_op("ld_f3_011", 1'b1, 1'b0, 1'b1, 3'd3, 32'h0000_7100, 32'h0, 32'h0, 0, 1);
    do_op("st_f3_100", 1'b0, 1'b1, 1'b1, 3'd4, 32'h0000_7200, 32'h11, 32'h0, 0, 0);
    do_op("rd_and_wr", 1'b1, 1'b1, 1'b1, 3'd2, 32'h0000_7300, 32'h22, 32'h0, 0, 1);
    do_op("sh_mis",    1'b0, 1'b1, 1'b1, 3'd1, 32'h0000_6001, 32'h33, 32'h0, 0, 0);
    do_op("lw_timeout",1'b1, 1'b0, 1'b1, 3'd2, 32'h0000_8000, 32'h0, 32'h0, -1, 0);

    // Reset while in WAIT, then a late rvalid that must be ignored.
    MemReadM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1;
    Funct3M = 3'd2; ALUResultM = 32'h0000_A000; bus_ready = 1'b1;
    @(negedge clk);
    check("rstw:issue_valid", 32'(bus_valid), 32'd1);
    @(posedge clk); #1;
    bus_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstw:stall_in_rst", 32'(StallM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    MemReadM = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    check("rstw:stall", 32'(StallM), 32'd0);
    check("rstw:bus_valid", 32'(bus_valid), 32'd0);
    check("rstw:read_data", ReadDataM, 32'd0);
    check("rstw:fault", 32'(MemFaultM), 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("rstw:late_rvalid", ReadDataM, 32'd0);
    check("rstw:no_fault", 32'(MemFaultM), 32'd0);
    @(posedge clk); #1;

    do_op("sb_after",  1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_9002, 32'h0000_003C, 32'h0, 0, 0);

    check("queues_empty", 32'(bus_q.size() + res_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule

// File: doc/pl_mem_lsu.md
Name: pl_mem_lsu

Overview:
Memory-stage load/store unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the M-stage memory controls, address and store data.
- Runs a valid/ready transaction on the data bus, with byte-lane steering and load extension.
- Drives ReadDataM and a gated RegWrite into MEM/WB.
- Stalls the pipeline while a transaction is outstanding and reports faults.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in REQ or WAIT before aborting with a bus-timeout fault
TO_W, 7, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
MemReadM  in  1  M-stage load
MemWriteM  in  1  M-stage store
Funct3M  in  3  access size/sign (RV32I encoding)
ALUResultM  in  32  effective address
WriteDataM  in  32  store data, unaligned (rs2)
RegWriteM  in  1  M-stage register-write enable
RegWriteOutM  out  1  gated RegWrite into MEM/WB
ReadDataM  out  32  extended load result
StallM  out  1  hold F/D/E/M stages
MemFaultM  out  1  one-cycle fault pulse
FaultCauseM  out  2  0 misaligned, 1 illegal funct3 / read+write, 2 bus timeout
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_we  out  1  write request
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data word

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE.
- Registered outputs reset to 0: ReadDataM, MemFaultM, FaultCauseM, the read buffer and the watchdog. All other outputs are combinational from state and inputs, and evaluate to 0 in reset/IDLE with no op.
- Upstream holds all M inputs stable whenever StallM=1.

IDLE:
- No op → StallM=0, RegWriteOutM=RegWriteM.
- Op with fault checks:
  - misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0;
  - illegal: Funct3 011/110/111, stores with Funct3 ≥100, or MemReadM&MemWriteM.
  - Response: no bus request, StallM=0, RegWriteOutM=0, MemFaultM=1 with cause next cycle for exactly one cycle; stay in IDLE.
- Legal op → StallM=1, bus_valid=1 in the same cycle.
  - bus_ready=1 → store: DONE; load: WAIT.
  - bus_ready=0 → REQ.

REQ:
- bus_valid=1 with stable address/data/strobes; StallM=1.
- On bus_ready → DONE (store) or WAIT (load).

WAIT:
- StallM=1, bus_valid=0.
- On bus_rvalid → capture bus_rdata into the read buffer, go to DONE.

DONE:
- StallM=0, RegWriteOutM=RegWriteM.
- ReadDataM is valid for loads; the extended value is registered on WAIT exit.
- Unconditionally → IDLE. The op is not re-issued.

Watchdog:
- Clears on entering REQ/WAIT; counts each cycle in REQ/WAIT.
- Reaching TIMEOUT_CYCLES → IDLE, StallM=0 that cycle, RegWriteOutM=0, MemFaultM pulse with cause 2, bus_valid dropped.

Store lane rules:
- SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
- SH: wdata = {2{h}}, wstrb = addr[1] ? 1100 : 0011.
- SW: wstrb = 1111.
- bus_we=0 and wstrb=0000 for loads.

Load extraction:
- LB/LBU take byte addr[1:0]; LH/LHU take half addr[1]; LW takes the full word.
- Sign-extend for LB/LH, zero-extend for LBU/LHU.

Minimum stall:
- Store: 1 cycle.
- Load: 2 cycles (ready in cycle N, rvalid in N+1, result in N+2).

Reset mid-transaction:
- State → IDLE; bus_valid low from the next cycle.
- A late rvalid is ignored.
- No fault pulse.

Decomposition:
- Shared package (pl_pkg): Funct3 load/store encodings, FaultCause codes, lsu_state_t enum.
- One sub-module, pl_lsu_align: combinational store lane steering/strobes and load extraction/extension, separately unit-testable.

Test Plan:
1. SB addr 0x1003, WriteDataM 0x000000A5, ready immediate → bus_wstrb=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, StallM high 1 cycle, then DONE.
2. LH addr 0x2002, bus_rdata 0x8001_1234, ready immediate, rvalid next cycle → ReadDataM=0xFFFF8001 in DONE, RegWriteOutM=1, StallM high exactly 2 cycles; LHU same access → 0x00008001.
3. LW addr 0x3001 → no bus_valid, StallM=0, RegWriteOutM=0, MemFaultM=1 cause 0 for one cycle.
4. LW with bus_ready low 5 cycles, rvalid 3 cycles later → bus_valid/address stable throughout REQ, ReadDataM equals bus_rdata, StallM high 9 cycles.
5. Load with bus_ready never asserted, TIMEOUT_CYCLES=64 → abort after 64 REQ cycles, MemFaultM cause 2, RegWriteOutM=0, FSM in IDLE.
6. rst asserted while in WAIT, then rvalid → state IDLE, StallM=0, all registered outputs 0, captured data not used; next legal store completes normally.
